// File: rtl/rbus_pkg.sv
// Shared types and constants for the reconfigurable line-buffer bus sequencer.
package rbus_pkg;

    localparam int MAX_LANES = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONF,
        ST_ACK,
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } rbus_state_e;

    typedef logic [MAX_LANES-1:0] lane_mask_t;

endpackage

// File: rtl/rbus_lane_mask.sv
// Combinational lane decode: one-hot write lane and the read mask of the other active lanes.
module rbus_lane_mask
    import rbus_pkg::*;
(
    input  logic [3:0] wr_lane_i,
    input  logic [3:0] w_rows_i,
    output lane_mask_t wr_onehot_o,
    output lane_mask_t rd_mask_o
);

    generate
        for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
            assign wr_onehot_o[gi] = (wr_lane_i == 4'(gi));
            assign rd_mask_o[gi]   = (4'(gi) < w_rows_i) && (wr_lane_i != 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/rbus_sequencer.sv
// Configures the line-buffer bus, then drives per-lane strobes from an accepted raster stream.
// Optional build macro RBSEQ_PARAM_CHECK_EN rejects illegal kernel/image shapes at Start.
module rbus_sequencer
    import rbus_pkg::*;
#(
    parameter int BITWIDTH_IMG        = 10,
    parameter int BITWIDTH_W_COLUMS   = 4,
    parameter int BITWIDTH_MAX_W_SIZE = 9
) (
    input  logic                           RBSEQ_Clk,
    input  logic                           RBSEQ_Reset,
    input  logic                           RBSEQ_Start,
    input  logic [3:0]                     RBSEQ_W_Rows,
    input  logic [BITWIDTH_W_COLUMS-1:0]   RBSEQ_W_Colums,
    input  logic [BITWIDTH_IMG-1:0]        RBSEQ_Img_Width,
    input  logic [BITWIDTH_IMG-1:0]        RBSEQ_Img_Height,
    input  logic                           RBSEQ_Pix_Valid,
    output logic                           RBSEQ_Pix_Ready,
    input  logic                           RBSEQ_Conf_Already,
    output logic                           RBSEQ_Set_Conf,
    output logic                           RBSEQ_Set_Conf_Already_Ok,
    output logic [BITWIDTH_MAX_W_SIZE-1:0] RBSEQ_W_ROXCL,
    output logic [MAX_LANES-1:0]           RBSEQ_SetEn,
    output logic [MAX_LANES-1:0]           RBSEQ_OEn,
    output logic [MAX_LANES-1:0]           RBSEQ_Wptclr,
    output logic [MAX_LANES-1:0]           RBSEQ_Rptclr,
    output logic                           RBSEQ_Window_Valid,
    output logic                           RBSEQ_Busy,
    output logic                           RBSEQ_Done,
    output logic                           RBSEQ_Error
);

    rbus_state_e state_q, state_d;
    logic [3:0]                     rows_q, rows_d;
    logic [BITWIDTH_W_COLUMS-1:0]   cols_q, cols_d;
    logic [BITWIDTH_IMG-1:0]        width_q, width_d, height_q, height_d;
    logic [BITWIDTH_IMG-1:0]        col_q, col_d, row_q, row_d;
    logic [3:0]                     lane_q, lane_d;
    logic [BITWIDTH_MAX_W_SIZE-1:0] roxcl_q, roxcl_d;
    lane_mask_t set_en_q, set_en_d, oen_q, oen_d, wptclr_q, wptclr_d, rptclr_q, rptclr_d;
    logic wv_q, wv_d, ready_q, ready_d, set_conf_q, set_conf_d, ok_q, ok_d;
    logic busy_q, busy_d, done_q, done_d, error_q, error_d;

    lane_mask_t wr_onehot, rd_mask;
    logic       accept, cfg_illegal;
    logic [BITWIDTH_IMG-1:0] cols_m1, width_m1, height_m1, rows_m2;

    rbus_lane_mask u_lane_mask (
        .wr_lane_i   (lane_q),
        .w_rows_i    (rows_q),
        .wr_onehot_o (wr_onehot),
        .rd_mask_o   (rd_mask)
    );

`ifdef RBSEQ_PARAM_CHECK_EN
    assign cfg_illegal = (RBSEQ_W_Rows == 4'd0) || (RBSEQ_W_Rows > 4'd13)
                      || (RBSEQ_W_Colums == '0) || (RBSEQ_W_Colums > BITWIDTH_W_COLUMS'(13))
                      || (RBSEQ_Img_Width < BITWIDTH_IMG'(RBSEQ_W_Colums))
                      || (RBSEQ_Img_Height < BITWIDTH_IMG'(RBSEQ_W_Rows));
`else
    assign cfg_illegal = 1'b0;
`endif

    assign cols_m1   = BITWIDTH_IMG'(cols_q) - BITWIDTH_IMG'(1);
    assign width_m1  = width_q - BITWIDTH_IMG'(1);
    assign height_m1 = height_q - BITWIDTH_IMG'(1);
    assign rows_m2   = BITWIDTH_IMG'(rows_q) - BITWIDTH_IMG'(2);
    assign accept    = RBSEQ_Pix_Valid && ((state_q == ST_FILL) || (state_q == ST_STREAM));

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        lane_d   = lane_q;
        roxcl_d  = roxcl_q;
        set_en_d = '0;
        oen_d    = '0;
        wptclr_d = '0;
        rptclr_d = '0;
        wv_d     = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RBSEQ_Start) begin
                    if (cfg_illegal) begin
                        error_d = 1'b1;
                    end else begin
                        rows_d   = RBSEQ_W_Rows;
                        cols_d   = RBSEQ_W_Colums;
                        width_d  = RBSEQ_Img_Width;
                        height_d = RBSEQ_Img_Height;
                        roxcl_d  = BITWIDTH_MAX_W_SIZE'(RBSEQ_W_Rows) * BITWIDTH_MAX_W_SIZE'(RBSEQ_W_Colums)
                                 - BITWIDTH_MAX_W_SIZE'(1);
                        col_d    = '0;
                        row_d    = '0;
                        lane_d   = '0;
                        state_d  = ST_CONF;
                    end
                end
            end
            ST_CONF: if (RBSEQ_Conf_Already) state_d = ST_ACK;
            ST_ACK:  state_d = (rows_q == 4'd1) ? ST_STREAM : ST_FILL;
            ST_FILL, ST_STREAM: begin
                if (accept) begin
                    set_en_d = wr_onehot;
                    if (col_q == '0) wptclr_d = wr_onehot;
                    if (state_q == ST_STREAM) begin
                        oen_d = rd_mask;
                        if (col_q == '0) rptclr_d = rd_mask;
                        wv_d = (col_q >= cols_m1);
                    end
                    if (col_q == width_m1) begin
                        col_d = '0;
                        // End of frame wins over end of row: the lane pointer is left alone.
                        if ((state_q == ST_STREAM) && (row_q == height_m1)) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d  = row_q + BITWIDTH_IMG'(1);
                            lane_d = (lane_q == rows_q - 4'd1) ? 4'd0 : lane_q + 4'd1;
                            if ((state_q == ST_FILL) && (row_q == rows_m2)) state_d = ST_STREAM;
                        end
                    end else begin
                        col_d = col_q + BITWIDTH_IMG'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Handshake and status outputs are registered copies of the upcoming state.
        set_conf_d = (state_d == ST_CONF);
        ok_d       = (state_d == ST_ACK);
        ready_d    = (state_d == ST_FILL) || (state_d == ST_STREAM);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_q == ST_DONE);
    end

    always_ff @(posedge RBSEQ_Clk) begin
        if (RBSEQ_Reset) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            lane_q     <= '0;
            roxcl_q    <= '0;
            set_en_q   <= '0;
            oen_q      <= '0;
            wptclr_q   <= '0;
            rptclr_q   <= '0;
            wv_q       <= 1'b0;
            ready_q    <= 1'b0;
            set_conf_q <= 1'b0;
            ok_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            lane_q     <= lane_d;
            roxcl_q    <= roxcl_d;
            set_en_q   <= set_en_d;
            oen_q      <= oen_d;
            wptclr_q   <= wptclr_d;
            rptclr_q   <= rptclr_d;
            wv_q       <= wv_d;
            ready_q    <= ready_d;
            set_conf_q <= set_conf_d;
            ok_q       <= ok_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign RBSEQ_Pix_Ready           = ready_q;
    assign RBSEQ_Set_Conf            = set_conf_q;
    assign RBSEQ_Set_Conf_Already_Ok = ok_q;
    assign RBSEQ_W_ROXCL             = roxcl_q;
    assign RBSEQ_SetEn               = set_en_q;
    assign RBSEQ_OEn                 = oen_q;
    assign RBSEQ_Wptclr              = wptclr_q;
    assign RBSEQ_Rptclr              = rptclr_q;
    assign RBSEQ_Window_Valid        = wv_q;
    assign RBSEQ_Busy                = busy_q;
    assign RBSEQ_Done                = done_q;
    assign RBSEQ_Error               = error_q;

endmodule

// File: tb/tb_rbus_sequencer.sv
// Directed bench for rbus_sequencer: config handshake, lane rotation, gaps, reset abort, param check.
module tb_rbus_sequencer;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  w_rows = '0;
    logic [3:0]  w_cols = '0;
    logic [9:0]  img_w = '0;
    logic [9:0]  img_h = '0;
    logic        pix_valid = 1'b0;
    logic        conf_already = 1'b0;
    logic        pix_ready, set_conf, conf_ok, window_valid, busy, done, error;
    logic [8:0]  w_roxcl;
    logic [12:0] set_en, oen, wptclr, rptclr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rbus_sequencer dut (
        .RBSEQ_Clk                 (clk),
        .RBSEQ_Reset               (srst),
        .RBSEQ_Start               (start),
        .RBSEQ_W_Rows              (w_rows),
        .RBSEQ_W_Colums            (w_cols),
        .RBSEQ_Img_Width           (img_w),
        .RBSEQ_Img_Height          (img_h),
        .RBSEQ_Pix_Valid           (pix_valid),
        .RBSEQ_Pix_Ready           (pix_ready),
        .RBSEQ_Conf_Already        (conf_already),
        .RBSEQ_Set_Conf            (set_conf),
        .RBSEQ_Set_Conf_Already_Ok (conf_ok),
        .RBSEQ_W_ROXCL             (w_roxcl),
        .RBSEQ_SetEn               (set_en),
        .RBSEQ_OEn                 (oen),
        .RBSEQ_Wptclr              (wptclr),
        .RBSEQ_Rptclr              (rptclr),
        .RBSEQ_Window_Valid        (window_valid),
        .RBSEQ_Busy                (busy),
        .RBSEQ_Done                (done),
        .RBSEQ_Error               (error)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_busy"},   32'(busy), 0);
        check_value({tag, "_ready"},  32'(pix_ready), 0);
        check_value({tag, "_conf"},   32'(set_conf), 0);
        check_value({tag, "_ok"},     32'(conf_ok), 0);
        check_value({tag, "_strobe"}, 32'(set_en | oen | wptclr | rptclr), 0);
        check_value({tag, "_wv"},     32'(window_valid), 0);
        check_value({tag, "_done"},   32'(done), 0);
        check_value({tag, "_err"},    32'(error), 0);
    endtask

    // Called at a falling edge; abort_at < 0 runs the whole frame.
    task automatic run_frame(input int rows, input int cols, input int w, input int h,
                             input bit gaps, input int abort_at, input int exp_roxcl,
                             input int exp_wv, input int exp_oen_row, input int exp_lanes);
        int total = w * h;
        int idx = 0;
        int pend = -1;
        int wv_cnt = 0;
        int first_oen_row = -1;
        int lanes_seen = 0;
        int r, c, lane, set_m, rd_m;
        bit strm;
        w_rows = 4'(rows);
        w_cols = 4'(cols);
        img_w  = 10'(w);
        img_h  = 10'(h);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("conf_req", 32'(set_conf), 1);
        check_value("busy_conf", 32'(busy), 1);
        check_value("roxcl", 32'(w_roxcl), 32'(exp_roxcl));
        repeat (2) begin
            @(negedge clk);
            check_value("conf_hold", 32'(set_conf), 1);
            check_value("ok_early", 32'(conf_ok), 0);
        end
        conf_already = 1'b1;
        @(negedge clk);
        conf_already = 1'b0;
        check_value("ok_pulse", 32'(conf_ok), 1);
        check_value("conf_drop", 32'(set_conf), 0);
        check_value("ready_in_ack", 32'(pix_ready), 0);
        @(negedge clk);
        check_value("ok_single", 32'(conf_ok), 0);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            set_m = 0; rd_m = 0; strm = 0; c = 1; r = 0;
            if (pend >= 0) begin
                r     = pend / w;
                c     = pend % w;
                lane  = r % rows;
                set_m = 1 << lane;
                strm  = (r >= rows - 1);
                rd_m  = strm ? (((1 << rows) - 1) & ~set_m) : 0;
                if (oen != 0 && first_oen_row < 0) first_oen_row = r;
            end
            check_value("set_en", 32'(set_en), 32'(set_m));
            check_value("wptclr", 32'(wptclr), (c == 0) ? 32'(set_m) : 0);
            check_value("oen",    32'(oen),    32'(rd_m));
            check_value("rptclr", 32'(rptclr), (c == 0) ? 32'(rd_m) : 0);
            check_value("win_valid", 32'(window_valid), 32'(strm && (c >= cols - 1)));
            check_value("err_quiet", 32'(error), 0);
            wv_cnt     += int'(window_valid);
            lanes_seen |= int'(set_en);
            pend = -1;
            if (idx == total || idx == abort_at) break;
            check_value("ready", 32'(pix_ready), 1);
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid) begin
                pend = idx;
                idx++;
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        if (idx != total && idx != abort_at) check_value("timeout", 32'(idx), 32'(total));
        if (abort_at < 0) begin
            check_value("ready_drop", 32'(pix_ready), 0);
            check_value("done_early", 32'(done), 0);
            check_value("busy_last", 32'(busy), 1);
            pix_valid = 1'b1;
            @(negedge clk);
            pix_valid = 1'b0;
            check_value("done_pulse", 32'(done), 1);
            check_value("busy_end", 32'(busy), 0);
            check_value("no_accept_done", 32'(set_en), 0);
            @(negedge clk);
            check_value("done_single", 32'(done), 0);
            check_value("wv_count", 32'(wv_cnt), 32'(exp_wv));
            check_value("first_oen_row", 32'(first_oen_row), 32'(exp_oen_row));
            check_value("lanes_used", 32'(lanes_seen), 32'(exp_lanes));
        end
        $display("frame rows=%0d cols=%0d w=%0d h=%0d gaps=%0d pixels=%0d windows=%0d",
                 rows, cols, w, h, gaps, idx, wv_cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        srst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        run_frame(3, 3, 8, 5, 1'b0, -1, 8, 18, 2, 32'h7);
        run_frame(1, 1, 4, 2, 1'b0, -1, 0, 8, -1, 32'h1);
        run_frame(13, 13, 13, 13, 1'b0, -1, 168, 1, 12, 32'h1FFF);
        run_frame(3, 3, 8, 5, 1'b1, -1, 8, 18, 2, 32'h7);

        // Abort in the middle of row 3 (streaming), then a fresh frame must still start.
        run_frame(3, 3, 8, 5, 1'b0, 30, 8, 0, 0, 0);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check_idle_outputs("abort");
        repeat (3) begin
            @(negedge clk);
            check_value("abort_no_done", 32'(done), 0);
        end
        run_frame(2, 3, 5, 3, 1'b0, -1, 5, 6, 1, 32'h3);

`ifdef RBSEQ_PARAM_CHECK_EN
        w_rows = 4'd14; w_cols = 4'd3; img_w = 10'd8; img_h = 10'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("err_pulse", 32'(error), 1);
        check_value("err_busy", 32'(busy), 0);
        check_value("err_conf", 32'(set_conf), 0);
        @(negedge clk);
        check_value("err_single", 32'(error), 0);
        check_value("err_conf2", 32'(set_conf), 0);
        $display("param check rows=14 error observed=%0d", n_fail == 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rbus_sequencer.md
# rbus_sequencer

Controller that configures and then drives the reconfigurable line-buffer bus. It requests the bus configuration for a given kernel shape and completes the configuration handshake. It then accepts a raster pixel stream and generates the 13 per-lane SetEn/OEn/Wptclr/Rptclr strobes, rotating the lanes as a ring of kernel-row buffers. It sits between the frame-level control (Nios-side registers) and the bus, one instance per convolution engine.

## Interface
- BITWIDTH_IMG, 10, width of image width/height fields
- BITWIDTH_W_COLUMS, 4, width of kernel column count
- BITWIDTH_MAX_W_SIZE, 9, width of rows×cols−1 output
- RBSEQ_Clk  in  1  clock; all logic on rising edge
- RBSEQ_Reset  in  1  synchronous, active-high reset
- RBSEQ_Start  in  1  start pulse; sampled only in IDLE
- RBSEQ_W_Rows  in  4  kernel rows, legal 1..13
- RBSEQ_W_Colums  in  BITWIDTH_W_COLUMS  kernel columns, legal 1..13
- RBSEQ_Img_Width  in  BITWIDTH_IMG  pixels per row, legal ≥ W_Colums
- RBSEQ_Img_Height  in  BITWIDTH_IMG  rows per frame, legal ≥ W_Rows
- RBSEQ_Pix_Valid  in  1  upstream pixel valid
- RBSEQ_Pix_Ready  out  1  pixel accepted when Valid&Ready
- RBSEQ_Conf_Already  in  1  bus reports configuration finished
- RBSEQ_Set_Conf  out  1  configuration request to bus
- RBSEQ_Set_Conf_Already_Ok  out  1  one-cycle acknowledge to bus
- RBSEQ_W_ROXCL  out  BITWIDTH_MAX_W_SIZE  W_Rows×W_Colums−1, latched at Start
- RBSEQ_SetEn, RBSEQ_OEn, RBSEQ_Wptclr, RBSEQ_Rptclr  out  13 each  lane strobes, bit k = lane k
- RBSEQ_Window_Valid  out  1  a full kernel window is available this cycle
- RBSEQ_Busy  out  1  not in IDLE
- RBSEQ_Done  out  1  one-cycle end-of-frame pulse
- RBSEQ_Error  out  1  one-cycle invalid-configuration pulse

## Operation
- States: IDLE → CONF → ACK → FILL → STREAM → DONE → IDLE.
- IDLE: on Start, latch all config inputs and compute W_ROXCL = rows×cols−1 (max 168, no overflow at 9 bits). Clear counters and go to CONF.
- CONF: Set_Conf=1 until Conf_Already=1, then go to ACK.
- ACK: Set_Conf_Already_Ok=1 for exactly one cycle, then go to FILL.
- Counters:
  - col: 0..Img_Width−1.
  - row: 0..Img_Height−1.
  - wr_lane: 0..W_Rows−1, wraps to 0 after W_Rows−1.
- Pix_Ready=1 only in FILL and STREAM.
- On each accepted pixel:
  - SetEn[wr_lane]=1.
  - If col==0, also Wptclr[wr_lane]=1.
  - At col==Img_Width−1: col→0, row++, wr_lane advances.
- FILL covers rows 0..W_Rows−2 and has no OEn. After the last pixel of row W_Rows−2, go to STREAM; with W_Rows==1, go from ACK straight to STREAM.
- STREAM, on each accepted pixel:
  - OEn=1 on the W_Rows−1 lanes other than wr_lane (all lanes <W_Rows).
  - If col==0, Rptclr=1 on the same lanes.
  - Window_Valid=1 when col ≥ W_Colums−1.
- After the last pixel of row Img_Height−1, go to DONE: Done=1 for one cycle, then IDLE.
- Lanes ≥ W_Rows never assert any strobe.
- Start outside IDLE is ignored.
- Pix_Valid=0 stalls: all strobes 0 and counters hold.

## Timing
- Reset value: every output 0, state IDLE. Reset in any state aborts the frame next edge; no Done.
- All outputs are registered. Strobes and Window_Valid appear exactly 1 cycle after the accepting edge, so the datapath delays pixel data by one register.
- Set_Conf is asserted 1 cycle after Start. Conf_Already seen at edge t gives Ok high in cycle t+1 only.
- Pix_Ready rises 1 cycle after ACK and drops in the cycle after the final accept; a Valid in the DONE cycle is not accepted.
- Simultaneous end-of-row and end-of-frame: DONE takes priority and wr_lane is not advanced.

## Configuration
- RBSEQ_PARAM_CHECK_EN defined: in IDLE, Start with any of the following pulses Error for 1 cycle and stays IDLE; nothing else toggles:
  - W_Rows==0 or >13
  - W_Colums==0 or >13
  - Img_Width<W_Colums
  - Img_Height<W_Rows
- Not defined: Error is tied 0, no checks are made, and behaviour with illegal values is unspecified.

## Structure
- Shared package rbus_pkg:
  - MAX_LANES=13
  - state enum (IDLE, CONF, ACK, FILL, STREAM, DONE)
  - lane mask type (13 bits)
- Sub-module rbus_lane_mask: combinational; wr_lane and W_Rows in → 13-bit write one-hot and read mask (active lanes minus wr_lane) out.

## Test plan
- Rows=3, Cols=3, W=8, H=5, continuous Valid:
  - W_ROXCL=8 and one Ok pulse.
  - Lanes used 0,1,2,0,1.
  - OEn first at row 2 on lanes {0,1}.
  - 18 Window_Valid pulses; Done 1 cycle after last strobe.
- Rows=1, Cols=1, W=4, H=2: ACK goes straight to STREAM; OEn never asserted; Window_Valid on all 8 pixels.
- Rows=13, Cols=13, W=13, H=13: W_ROXCL=168; all 13 lanes written once; exactly 1 Window_Valid.
- Random Valid gaps (50%) on the 3×3 case: strobe sequence identical to the continuous case with gaps removed; no strobes in gap cycles.
- Reset asserted mid-STREAM: all outputs 0 the next cycle, no Done; a new Start is accepted.
- With RBSEQ_PARAM_CHECK_EN, Rows=14: Error pulse, Busy stays 0, Set_Conf never asserted.
